// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: PC/instruction words, FIFO entry, FSM states.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] pc_t;
  typedef logic [XLEN-1:0] instr_t;

  typedef struct packed {
    pc_t    pc;
    instr_t instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: InstructionMemory read port, execute redirect, decode handshake.
interface instruction_fetch_if;
  import fetch_pkg::*;

  pc_t    Address;
  instr_t Instruction;
  logic   RedirectValid;
  pc_t    RedirectTarget;
  logic   OutValid;
  logic   OutReady;
  instr_t OutInstruction;
  pc_t    OutPc;

  modport master (
    output Address,
    input  Instruction,
    input  RedirectValid,
    input  RedirectTarget,
    output OutValid,
    input  OutReady,
    output OutInstruction,
    output OutPc
  );

  modport slave (
    input  Address,
    output Instruction,
    output RedirectValid,
    output RedirectTarget,
    input  OutValid,
    output OutReady,
    input  OutInstruction,
    input  OutPc
  );

endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry FIFO of fetch entries; flush beats push, a same-cycle head pop is honoured.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  fetch_entry_t                 entry_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output fetch_entry_t                 head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= entry_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads InstructionMemory, buffers {pc, instr} for decode, handles redirects.
// Optional FETCH_PERF_EN adds FetchCount/StallCycles counters.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter pc_t         RESET_PC = 32'd0,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                Clk,
  input  logic                Rst_n,
  instruction_fetch_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         FetchCount,
  output logic [31:0]         StallCycles
`endif
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned UW = CW + 1;

  fetch_state_t  state_q, state_d;
  pc_t           pc_q, pc_d;
  pc_t           tag_q, tag_d;
  logic          inflight_q, inflight_d;

  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  capture;
  logic          pop;
  logic          redirect;
  logic          credit_ok;
  logic          issue;
  logic [UW-1:0] used;

  assign redirect  = bus.RedirectValid;
  assign pop       = bus.OutValid & bus.OutReady;
  // Slots committed after this edge: buffered + in flight, minus the entry leaving now.
  assign used      = UW'(count) + UW'(inflight_q) - UW'(pop);
  assign credit_ok = used < UW'(DEPTH);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (!redirect && !credit_ok) state_d = HOLD;
      HOLD:    if (redirect || credit_ok)   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // In HOLD the FIFO is exactly full with nothing in flight, so only a pop frees a slot.
  always_comb begin
    issue      = 1'b0;
    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = 1'b0;
    if (redirect) begin
      pc_d = bus.RedirectTarget;
    end else begin
      unique case (state_q)
        RUN:     issue = credit_ok;
        HOLD:    issue = pop;
        default: issue = 1'b0;
      endcase
      if (issue) begin
        pc_d       = pc_q + 32'd1;
        tag_d      = pc_q;
        inflight_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pc_q       <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  assign capture = '{pc: tag_q, instr: bus.Instruction};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .push_i  (inflight_q),
    .entry_i (capture),
    .pop_i   (pop),
    .flush_i (redirect),
    .head_o  (head),
    .count_o (count)
  );

  assign bus.Address        = pc_q;
  assign bus.OutValid       = (count != '0);
  assign bus.OutInstruction = head.instr;
  assign bus.OutPc          = head.pc;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q;
  logic [31:0] stall_cycles_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      fetch_count_q  <= '0;
      stall_cycles_q <= '0;
    end else begin
      fetch_count_q  <= fetch_count_q + 32'(pop);
      stall_cycles_q <= stall_cycles_q + 32'(!bus.OutValid);
    end
  end

  assign FetchCount  = fetch_count_q;
  assign StallCycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus random ready/redirect traffic
// against a stream-level model (consecutive PCs from the last reset/redirect, valid two edges later).
module tb_instruction_fetch;
  import fetch_pkg::*;

  logic Clk;
  logic Rst_n;
  instruction_fetch_if bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_cycles;
`endif

  instruction_fetch #(.RESET_PC(32'd0), .DEPTH(2)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
`ifdef FETCH_PERF_EN
    ,
    .FetchCount  (fetch_count),
    .StallCycles (stall_cycles)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h12345678;
      32'd1:   return 32'h9ABCDEF0;
      32'd2:   return 32'h2468ACEF;
      32'd3:   return 32'h13579BDF;
      32'd4:   return 32'h11112222;
      32'd5:   return 32'h33334444;
      32'd6:   return 32'h55556666;
      32'd7:   return 32'h77778888;
      default: return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endcase
  endfunction

  // One-cycle-latency memory
  logic [31:0] mem_rd;
  always @(posedge Clk) mem_rd <= memf(bus.Address);
  assign bus.Instruction = mem_rd;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] exp_pc;
  int          since_redirect;
  logic [31:0] m_fetch;
  logic [31:0] m_stall;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge: check current outputs, drive inputs, advance through one posedge.
  task automatic step(input logic rdy, input logic rv, input logic [31:0] tgt);
    logic ev;
    ev = (since_redirect >= 2);
    check_eq("out_valid", 32'(bus.OutValid), 32'(ev));
    if (ev) begin
      check_eq("out_pc", bus.OutPc, exp_pc);
      check_eq("out_instr", bus.OutInstruction, memf(exp_pc));
    end
`ifdef FETCH_PERF_EN
    check_eq("fetch_count", fetch_count, m_fetch);
    check_eq("stall_cycles", stall_cycles, m_stall);
`endif
    bus.OutReady       = rdy;
    bus.RedirectValid  = rv;
    bus.RedirectTarget = tgt;
    @(posedge Clk);
    if (ev && rdy) begin
      exp_pc  = exp_pc + 32'd1;
      m_fetch = m_fetch + 32'd1;
    end
    if (!ev) m_stall = m_stall + 32'd1;
    if (rv) begin
      exp_pc         = tgt;
      since_redirect = 0;
    end else if (since_redirect < 3) begin
      since_redirect++;
    end
    @(negedge Clk);
  endtask

  // Assert reset between edges, check outputs clear at once, release on the next negedge.
  task automatic do_reset();
    #2;
    Rst_n = 1'b0;
    #1;
    check_eq("rst_valid", 32'(bus.OutValid), 32'd0);
    check_eq("rst_addr", bus.Address, 32'd0);
    check_eq("rst_pc", bus.OutPc, 32'd0);
    check_eq("rst_instr", bus.OutInstruction, 32'd0);
`ifdef FETCH_PERF_EN
    check_eq("rst_fetch_count", fetch_count, 32'd0);
    check_eq("rst_stall_cycles", stall_cycles, 32'd0);
`endif
    bus.OutReady       = 1'b0;
    bus.RedirectValid  = 1'b0;
    bus.RedirectTarget = '0;
    @(negedge Clk);
    Rst_n          = 1'b1;
    exp_pc         = 32'd0;
    since_redirect = 0;
    m_fetch        = '0;
    m_stall        = '0;
  endtask

  initial begin
    logic [31:0] tgt;
    Rst_n              = 1'b0;
    bus.OutReady       = 1'b0;
    bus.RedirectValid  = 1'b0;
    bus.RedirectTarget = '0;
    @(negedge Clk);
    do_reset();

    // Reset release, streaming 0..3
    repeat (6) step(1'b1, 1'b0, '0);

    // Backpressure: head holds, Address parks at 2, then drains in order
    do_reset();
    repeat (10) step(1'b0, 1'b0, '0);
    check_eq("addr_stall", bus.Address, 32'd2);
    repeat (6) step(1'b1, 1'b0, '0);

    // Redirect with FIFO full
    repeat (3) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'd6);
    repeat (5) step(1'b1, 1'b0, '0);

    // Redirect coinciding with pop of pc 1
    do_reset();
    repeat (3) step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 32'd4);
    repeat (4) step(1'b1, 1'b0, '0);

    // Mid-stream reset, then the startup sequence repeats
    do_reset();
    repeat (6) step(1'b1, 1'b0, '0);

    // Counter scenario: two empty cycles then four pops
    do_reset();
    repeat (6) step(1'b1, 1'b0, '0);
`ifdef FETCH_PERF_EN
    check_eq("perf_fetch4", fetch_count, 32'd4);
    check_eq("perf_stall2", stall_cycles, 32'd2);
`endif

    // Back-to-back redirects: latest wins
    step(1'b1, 1'b1, 32'd100);
    step(1'b1, 1'b1, 32'd200);
    repeat (5) step(1'b1, 1'b0, '0);

    // PC wrap
    step(1'b1, 1'b1, 32'hFFFFFFFE);
    repeat (6) step(1'b1, 1'b0, '0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       tgt = 32'($urandom_range(0, 7));
        1:       tgt = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
        default: tgt = $urandom;
      endcase
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), tgt);
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
